// File: rtl/button_event_pkg.sv
// Shared encodings for the button event controller: event codes,
// per-channel state encodings and event field widths.
package button_event_pkg;

  localparam int EV_W       = 2;
  localparam int N_EV_KINDS = 3;

  typedef enum logic [EV_W-1:0] {
    EV_PRESS   = 2'd0,
    EV_LONG    = 2'd1,
    EV_RELEASE = 2'd2
  } ev_type_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } ch_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One button debouncer: a saturating run-length counter of high samples and
// a registered level that rises once the run reaches DEBOUNCE_CYCLES.
module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_held
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_held;

  // held follows the pre-edge count, so it lags the count by one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_held <= 1'b0;
    end else begin
      r_held <= (r_cnt >= CNT_W'(DEBOUNCE_CYCLES));
      if (!i_raw)
        r_cnt <= '0;
      else if (r_cnt != CNT_W'(DEBOUNCE_CYCLES))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_held = r_held;

endmodule

// File: rtl/button_event_controller.sv
// Debounced buttons -> per-channel press/long/release FSMs -> pending flags
// -> fixed-priority scheduler -> small event FIFO with a valid/ready head.
module button_event_controller
  import button_event_pkg::*;
#(
  parameter int N_BUTTONS       = 4,
  parameter int DEBOUNCE_CYCLES = 15,
  parameter int LONG_CYCLES     = 1000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_BUTTONS-1:0]         button_in,
  output logic [N_BUTTONS-1:0]         held,
  output logic                         event_valid,
  input  logic                         event_ready,
  output logic [$clog2(N_BUTTONS)-1:0] event_button,
  output logic [1:0]                   event_type,
  output logic                         overflow,
  input  logic                         clear_overflow
);

  localparam int BTN_W   = $clog2(N_BUTTONS);
  localparam int HOLD_W  = $clog2(LONG_CYCLES + 1);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int N_FLAGS = N_BUTTONS * N_EV_KINDS;

  logic [N_BUTTONS-1:0] w_held, r_held_d, w_rise, w_fall;
  ch_state_e            r_state     [N_BUTTONS];
  ch_state_e            w_state_nxt [N_BUTTONS];
  logic [HOLD_W-1:0]    r_hold      [N_BUTTONS];
  logic [HOLD_W-1:0]    w_hold_nxt  [N_BUTTONS];

  logic [N_FLAGS-1:0]   r_pend, w_set, w_first, w_grant;
  logic                 w_any, w_push, w_pop, w_full, w_valid, w_drop;
  logic [BTN_W-1:0]     w_sel_btn;
  logic [EV_W-1:0]      w_sel_type;

  logic [BTN_W-1:0]     r_mem_btn  [FIFO_DEPTH];
  logic [EV_W-1:0]      r_mem_type [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr, r_rd;
  logic [CNT_W-1:0]     r_count;
  logic                 r_overflow;

  for (genvar g = 0; g < N_BUTTONS; g++) begin : g_db
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .reset (reset),
      .i_raw (button_in[g]),
      .o_held(w_held[g])
    );
  end

  assign w_rise = w_held & ~r_held_d;
  assign w_fall = ~w_held & r_held_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_held_d <= '0;
      for (int i = 0; i < N_BUTTONS; i++) begin
        r_state[i] <= ST_IDLE;
        r_hold[i]  <= '0;
      end
    end else begin
      r_held_d <= w_held;
      for (int i = 0; i < N_BUTTONS; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_hold[i]  <= w_hold_nxt[i];
      end
    end
  end

  // Channel FSMs raise one-cycle event requests into w_set
  always_comb begin
    w_set = '0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      w_state_nxt[i] = r_state[i];
      w_hold_nxt[i]  = r_hold[i];
      case (r_state[i])
        ST_IDLE: begin
          if (w_rise[i]) begin
            w_state_nxt[i] = ST_PRESSED;
            w_hold_nxt[i]  = '0;
            w_set[i*N_EV_KINDS + int'(EV_PRESS)] = 1'b1;
          end
        end
        ST_PRESSED: begin
          if (w_fall[i]) begin
            w_state_nxt[i] = ST_IDLE;
            w_set[i*N_EV_KINDS + int'(EV_RELEASE)] = 1'b1;
          end else begin
            w_hold_nxt[i] = r_hold[i] + 1'b1;
            if (r_hold[i] == HOLD_W'(LONG_CYCLES - 1)) begin
              w_state_nxt[i] = ST_LONG;
              w_set[i*N_EV_KINDS + int'(EV_LONG)] = 1'b1;
            end
          end
        end
        ST_LONG: begin
          if (w_fall[i]) begin
            w_state_nxt[i] = ST_IDLE;
            w_set[i*N_EV_KINDS + int'(EV_RELEASE)] = 1'b1;
          end
        end
        default: w_state_nxt[i] = ST_IDLE;
      endcase
    end
  end

  // Flag index = channel*3 + event code, so the lowest set bit is the winner
  always_comb begin
    w_any      = 1'b0;
    w_first    = '0;
    w_sel_btn  = '0;
    w_sel_type = '0;
    for (int k = 0; k < N_FLAGS; k++) begin
      if (r_pend[k] && !w_any) begin
        w_any      = 1'b1;
        w_first[k] = 1'b1;
        w_sel_btn  = BTN_W'(k / N_EV_KINDS);
        w_sel_type = EV_W'(k % N_EV_KINDS);
      end
    end
  end

  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_valid = (r_count != '0);
  assign w_push  = w_any && !w_full;
  assign w_pop   = w_valid && event_ready;
  assign w_grant = w_push ? w_first : '0;
  // A flag being moved into the FIFO this edge can accept a new event
  assign w_drop  = |(w_set & r_pend & ~w_grant);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend     <= '0;
      r_wr       <= '0;
      r_rd       <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_pend <= (r_pend & ~w_grant) | w_set;
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop)
        r_overflow <= 1'b1;
      else if (clear_overflow)
        r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_btn[r_wr]  <= w_sel_btn;
      r_mem_type[r_wr] <= w_sel_type;
    end
  end

  assign held         = w_held;
  assign event_valid  = w_valid;
  assign event_button = w_valid ? r_mem_btn[r_rd] : '0;
  assign event_type   = w_valid ? r_mem_type[r_rd] : '0;
  assign overflow     = r_overflow;

endmodule

// File: doc/button_event_controller.md
# button_event_controller

Turns raw push-button levels into a queued stream of discrete button events. Debounces each of N buttons, runs a per-button press/long-press/release state machine, arbitrates simultaneous events into a small FIFO, and presents them on a valid/ready interface to the game/menu logic. It sits between the board button pins and all control FSMs that currently consume raw debounced levels.

## Interface
- N_BUTTONS, 4: number of button channels.
- DEBOUNCE_CYCLES, 15: consecutive high samples required before a button counts as pressed.
- LONG_CYCLES, 1000: cycles in PRESSED before a LONG event is raised.
- FIFO_DEPTH, 4: event queue entries (power of two).
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- button_in  input  N_BUTTONS  raw button levels, 1 = pressed; treated as already synchronised.
- held  output  N_BUTTONS  debounced button levels.
- event_valid  output  1  FIFO head is valid.
- event_ready  input  1  consumer accepts head; pop when event_valid && event_ready.
- event_button  output  clog2(N_BUTTONS)  channel index of head event.
- event_type  output  2  0 PRESS, 1 LONG, 2 RELEASE.
- overflow  output  1  sticky: an event was lost.
- clear_overflow  input  1  synchronous clear of overflow.

## Operation
- Debounce per channel: raw low clears counter to 0; raw high increments it, saturating at DEBOUNCE_CYCLES. held[i] is registered: held[i] <= (counter >= DEBOUNCE_CYCLES), evaluated on the pre-edge counter.
- Channel FSM, states IDLE, PRESSED, LONG; rise/fall of held[i] is detected against a registered copy of held[i].
- IDLE -> PRESSED on rise: set PRESS pending, clear hold counter.
- PRESSED: hold counter +1 per cycle; at LONG_CYCLES -> LONG, set LONG pending.
- PRESSED or LONG -> IDLE on fall: set RELEASE pending.
- Pending flags: 3 per channel. Setting a flag already set drops the new event and sets overflow.
- Scheduler: each cycle, if FIFO count < FIFO_DEPTH and any flag set, push one event: lowest channel index first, within a channel PRESS, then LONG, then RELEASE; clear that flag the same edge.
- FIFO full: no push; flags wait (not overflow). Push is blocked at full even if a pop occurs that cycle.
- Pop and push in the same cycle when not full: both occur; count unchanged.
- overflow: set on drop; clear_overflow clears; a drop in the same cycle as clear_overflow wins (stays 1).
- Hold counter width clog2(LONG_CYCLES+1); no wrap, stops counting in LONG.

## Timing
- Reset values: held 0, event_valid 0, event_button 0, event_type 0, overflow 0; all counters 0, FSMs IDLE, flags 0, FIFO empty.
- Press latency: raw high first sampled at edge 1 -> held high after edge DEBOUNCE_CYCLES+1 -> PRESS pending after edge +2 -> event_valid high after edge DEBOUNCE_CYCLES+3 (empty FIFO, no contention).
- Release: raw low sampled at edge R -> held low after R+1 -> RELEASE pending after R+2 -> event_valid after R+3.
- A raw glitch shorter than DEBOUNCE_CYCLES samples produces no event.
- event_button/event_type stable while event_valid && !event_ready.
- Reset mid-operation: everything clears immediately; a button still held afterwards re-debounces and yields a fresh PRESS; no RELEASE is generated for the pre-reset press.

## Structure
- Package button_event_pkg: EV_PRESS/EV_LONG/EV_RELEASE codes, channel state encodings (ST_IDLE, ST_PRESSED, ST_LONG), event width constants.
- Sub-module debounce_channel: one counter + registered level, instantiated N_BUTTONS times. FSMs, scheduler and FIFO stay in the top.

## Test plan
- Bench overrides LONG_CYCLES=40. Button 0 high 20 cycles, then low -> PRESS(0) valid at cycle 18, RELEASE(0) follows; no LONG; held[0] high exactly while debounced.
- Button 2 high for 10 cycles, low, repeated 5 times -> no events, held[2] stays 0.
- Button 1 held 100 cycles -> PRESS(1), then LONG(1) 40 cycles after PRESS pending, then RELEASE(1) after release.
- Buttons 3 and 0 rise same cycle -> queue order PRESS(0), PRESS(3).
- event_ready=0, 5 distinct events generated -> 4 queued, fifth waits as pending and emerges after one pop; overflow stays 0; a repeated press while its PRESS is still pending sets overflow=1, clear_overflow returns it to 0.
- Reset asserted while button 0 is in LONG with 2 queued events -> event_valid 0 immediately; after release of reset with button held, a single fresh PRESS(0) appears.
